dice_roll_qualifier: RTL and testbench
======================================

Name: dice_roll_qualifier

Overview:
- Sits between the colour detector and the game logic controller, in the pixel-clock domain.
- Qualifies the detector's per-frame colour results into exactly one handshaked dice result per physical roll.
- A result is accepted only after the tray has been empty (white) for a set number of frames, followed by a run of agreeing, non-white colour samples.
- Also provides timeout recovery when the colour never settles, and a lockout that prevents double-counting one roll.

Parameters:
- SETTLE_COUNT, 4: consecutive identical non-white colour samples required to accept a roll (legal range 1..63).
- REARM_FRAMES, 8: consecutive white frames required before a new roll is accepted (legal range 1..63).
- TIMEOUT_FRAMES, 60: frames allowed in SETTLE before the attempt is abandoned (legal range 2..63).
- CNT_W, 6: width of the internal counters.

Ports:
- clk  input  1  pixel clock; all logic runs on its rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  level; high only while the game state is active.
- frame_tick  input  1  single-cycle pulse, one per frame end.
- color_valid  input  1  single-cycle pulse marking a new detector result (the detector's result_ready).
- color_code  input  2  detector stable colour; valid while color_valid=1.
- white_present  input  1  level; the detector reports the tray as empty/white.
- dice_ack  input  1  consumer accepts the current result.
- dice_valid  output  1  result available; held until acknowledged.
- dice_value  output  2  qualified colour code.
- dice_steps  output  3  dice_value+1, range 1..4.
- timeout_err  output  1  single-cycle pulse when a settle attempt is abandoned.
- busy  output  1  high in the SETTLE or REPORT state.
- state_dbg  output  3  encoded state: IDLE=0, REARM=1, ARMED=2, SETTLE=3, REPORT=4.

Behaviour:
- Reset:
  - state=IDLE.
  - All counters are 0, and the candidate is 0.
  - dice_valid=0, dice_value=0, dice_steps=1, timeout_err=0, busy=0, state_dbg=0.
- Registered outputs: all outputs are registered and reflect the state after each edge. There is no combinational input-to-output path.
- enable=0: in any state this forces IDLE on the next edge. dice_valid drops, all counters clear, and no timeout_err is generated. enable has priority over every other input except reset.
- IDLE: when enable=1, go to REARM with wcnt=0.
- REARM, evaluated only on frame_tick:
  - white_present=1: wcnt++.
  - white_present=0: wcnt=0.
  - A tick with white_present=1 and wcnt==REARM_FRAMES-1 moves to ARMED.
  - color_valid is ignored in this state.
- ARMED:
  - color_valid=1 with white_present=0: latch cand=color_code, agree=1, tcnt=0.
    - If SETTLE_COUNT==1, go to REPORT.
    - Otherwise go to SETTLE.
  - color_valid with white_present=1 is ignored.
  - There is no timeout in ARMED.
- SETTLE:
  - color_valid with white_present=0 and color_code==cand: agree++. Reaching agree==SETTLE_COUNT moves to REPORT.
  - color_valid with white_present=0 and color_code!=cand: cand=color_code, agree=1. tcnt is not reset.
  - color_valid with white_present=1: return to ARMED with agree=0, because the dice was removed.
  - frame_tick: tcnt++. When tcnt reaches TIMEOUT_FRAMES, pulse timeout_err for one cycle and go to REARM with wcnt=0.
  - If color_valid and frame_tick arrive in the same cycle, the colour is evaluated first. A transition to REPORT or ARMED suppresses the timeout.
- REPORT:
  - dice_valid=1, with dice_value=cand and dice_steps=cand+1 held constant.
  - dice_ack is honoured only while dice_valid=1. On the edge where dice_ack=1, dice_valid clears and the state goes to REARM with wcnt=0.
  - The roll may stay in place indefinitely. New color_valid pulses are ignored and cannot modify dice_value.
- dice_ack outside REPORT: ignored, with no side effects.
- Counters: saturate and never wrap. Widths are checked against CNT_W.

Test Plan:
- Normal roll: enable=1; 8 ticks with white=1; then 4 color_valid pulses with code=2, white=0. Required: dice_valid rises the cycle after the 4th pulse, with dice_value=2 and dice_steps=3. Ack: dice_valid falls on the next edge and state_dbg=1.
- Lockout / no double count: after the ack, continue color_valid code=2, white=0 for 20 frames. Required: no dice_valid; state stays REARM (state_dbg=1).
- Flicker restart: with the dice armed, send codes 1,1,3,3,3,3. Required: dice_valid with dice_value=3 after the 6th sample. Repeat with the sequence 1,1,white: required state returns to ARMED (state_dbg=2).
- Timeout: with the dice armed, send one code=0 and then no further agreement for 60 ticks. Required: timeout_err pulses for exactly one cycle on the 60th tick, and state_dbg=1. With color_valid completing the settle on the same cycle as that tick, required: REPORT and no timeout_err.
- Enable drop: deassert enable while in REPORT with dice_valid=1. Required: next edge gives dice_valid=0, state_dbg=0, and no timeout_err.
- Reset mid-SETTLE: required all outputs at reset values on the next edge. A stray dice_ack in IDLE or ARMED has no effect.

Source files
------------

// File: rtl/dice_roll_qualifier_if.sv
// -----------------------------------------------------------------------------
// dice_roll_qualifier_if
//
// Groups every signal of the dice roll qualifier except clk and reset.
//
// Producer-side signals (driven by the master: detector, game controller):
//   enable        level, game state active
//   frame_tick    one-cycle pulse per frame end
//   color_valid   one-cycle pulse, new detector result
//   color_code    detector colour, meaningful while color_valid=1
//   white_present level, tray reported empty/white
//   dice_ack      consumer accepts the current result
// Qualifier-side signals (driven by the slave, the qualifier itself):
//   dice_valid    result available, held until acknowledged
//   dice_value    qualified colour code
//   dice_steps    dice_value + 1 (1..4)
//   timeout_err   one-cycle pulse when a settle attempt is abandoned
//   busy          high while settling or reporting
//   state_dbg     encoded state (IDLE=0 REARM=1 ARMED=2 SETTLE=3 REPORT=4)
// -----------------------------------------------------------------------------
interface dice_roll_qualifier_if;
  logic       enable;
  logic       frame_tick;
  logic       color_valid;
  logic [1:0] color_code;
  logic       white_present;
  logic       dice_ack;
  logic       dice_valid;
  logic [1:0] dice_value;
  logic [2:0] dice_steps;
  logic       timeout_err;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output enable, frame_tick, color_valid, color_code, white_present, dice_ack,
    input  dice_valid, dice_value, dice_steps, timeout_err, busy, state_dbg
  );

  modport slave (
    input  enable, frame_tick, color_valid, color_code, white_present, dice_ack,
    output dice_valid, dice_value, dice_steps, timeout_err, busy, state_dbg
  );
endinterface

// File: rtl/dice_roll_qualifier.sv
// -----------------------------------------------------------------------------
// dice_roll_qualifier
//
// Turns the colour detector's per-frame results into exactly one handshaked
// dice result per physical roll. A roll is only accepted after the tray has
// been seen white for REARM_FRAMES consecutive frame ticks, followed by
// SETTLE_COUNT agreeing non-white samples. A settle attempt that does not
// converge within TIMEOUT_FRAMES frame ticks is abandoned with a one-cycle
// timeout_err pulse. After a result is acknowledged the block re-arms, so the
// same dice still lying in the tray cannot be counted twice.
//
// Ports:
//   clk    pixel clock, rising edge
//   reset  synchronous, active-high
//   bus    dice_roll_qualifier_if.slave (see the interface for signal list)
//
// Parameters (legal ranges): SETTLE_COUNT 1..63, REARM_FRAMES 1..63,
// TIMEOUT_FRAMES 2..63, all of which must fit in CNT_W-bit counters.
// -----------------------------------------------------------------------------
module dice_roll_qualifier #(
  parameter int SETTLE_COUNT   = 4,
  parameter int REARM_FRAMES   = 8,
  parameter int TIMEOUT_FRAMES = 60,
  parameter int CNT_W          = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  dice_roll_qualifier_if.slave  bus
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Elaboration-time guards: a parameter that does not fit the counters
  // would make a terminal count unreachable.
  if (SETTLE_COUNT < 1 || SETTLE_COUNT > CNT_MAX) begin : g_bad_settle
    $error("SETTLE_COUNT out of range for CNT_W");
  end
  if (REARM_FRAMES < 1 || REARM_FRAMES > CNT_MAX) begin : g_bad_rearm
    $error("REARM_FRAMES out of range for CNT_W");
  end
  if (TIMEOUT_FRAMES < 2 || TIMEOUT_FRAMES > CNT_MAX) begin : g_bad_timeout
    $error("TIMEOUT_FRAMES out of range for CNT_W");
  end

  // Terminal counts in counter width. The "_LAST" values are compared against
  // the pre-increment count, so the event fires on the tick that completes N.
  localparam logic [CNT_W-1:0] SETTLE_C     = CNT_W'(SETTLE_COUNT);
  localparam logic [CNT_W-1:0] REARM_LAST   = CNT_W'(REARM_FRAMES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REARM  = 3'd1,
    ST_ARMED  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_ONE;
  endfunction

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] wcnt_q,       wcnt_d;   // consecutive white frame ticks
  logic [CNT_W-1:0] agree_q,      agree_d;  // consecutive matching samples
  logic [CNT_W-1:0] tcnt_q,       tcnt_d;   // frame ticks spent settling
  logic [1:0]       cand_q,       cand_d;   // colour currently being settled
  logic             dice_valid_q, dice_valid_d;
  logic [1:0]       dice_value_q, dice_value_d;
  logic             timeout_q,    timeout_d;
  logic             busy_q,       busy_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    agree_d   = agree_q;
    tcnt_d    = tcnt_q;
    cand_d    = cand_q;
    timeout_d = 1'b0;

    if (!bus.enable) begin
      // Leaving the game state abandons everything, silently.
      state_d = ST_IDLE;
      wcnt_d  = '0;
      agree_d = '0;
      tcnt_d  = '0;
      cand_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_REARM;
          wcnt_d  = '0;
        end

        // Wait for an unbroken run of white frames; colour samples are
        // ignored here, which is what blocks double-counting a dice that is
        // still lying in the tray after its result was acknowledged.
        ST_REARM: begin
          if (bus.frame_tick) begin
            if (bus.white_present) begin
              wcnt_d = sat_inc(wcnt_q);
              if (wcnt_q == REARM_LAST) state_d = ST_ARMED;
            end else begin
              wcnt_d = '0;
            end
          end
        end

        // First non-white sample starts a settle attempt.
        ST_ARMED: begin
          if (bus.color_valid && !bus.white_present) begin
            cand_d  = bus.color_code;
            agree_d = CNT_ONE;
            tcnt_d  = '0;
            state_d = (SETTLE_COUNT == 1) ? ST_REPORT : ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          // Colour is evaluated before the frame tick.
          if (bus.color_valid) begin
            if (bus.white_present) begin
              // Dice removed mid-settle: wait for the next one.
              state_d = ST_ARMED;
              agree_d = '0;
            end else if (bus.color_code == cand_q) begin
              agree_d = sat_inc(agree_q);
              if (agree_d >= SETTLE_C) state_d = ST_REPORT;
            end else begin
              // Still rolling: restart agreement on the new colour but keep
              // the timeout running so a flickering dice cannot stall us.
              cand_d  = bus.color_code;
              agree_d = CNT_ONE;
            end
          end
          // A colour decision that already left SETTLE suppresses the timeout.
          if (bus.frame_tick && state_d == ST_SETTLE) begin
            tcnt_d = sat_inc(tcnt_q);
            if (tcnt_q == TIMEOUT_LAST) begin
              timeout_d = 1'b1;
              state_d   = ST_REARM;
              wcnt_d    = '0;
            end
          end
        end

        ST_REPORT: begin
          if (bus.dice_ack && dice_valid_q) begin
            state_d = ST_REARM;
            wcnt_d  = '0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output registers are computed from the next state so that every output
  // describes the state after the edge without any input-to-output path.
  always_comb begin
    dice_valid_d = (state_d == ST_REPORT);
    busy_d       = (state_d == ST_SETTLE) || (state_d == ST_REPORT);
    // The reported value is captured once on entry and held while reporting.
    dice_value_d = (state_d == ST_REPORT && state_q != ST_REPORT) ? cand_d
                                                                  : dice_value_q;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  // NOTE: reset is synchronous and covers every register; there is no memory
  // array here that would need to be left out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      agree_q      <= '0;
      tcnt_q       <= '0;
      cand_q       <= '0;
      dice_valid_q <= 1'b0;
      dice_value_q <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      agree_q      <= agree_d;
      tcnt_q       <= tcnt_d;
      cand_q       <= cand_d;
      dice_valid_q <= dice_valid_d;
      dice_value_q <= dice_value_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dice_valid  = dice_valid_q;
  assign bus.dice_value  = dice_value_q;
  assign bus.dice_steps  = {1'b0, dice_value_q} + 3'd1;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = busy_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_dice_roll_qualifier.sv
// -----------------------------------------------------------------------------
// tb_dice_roll_qualifier
//
// Drives directed roll scenarios followed by randomized traffic. A reference
// model applies the qualification rules to each cycle's inputs and pushes the
// expected results/timeouts into a queue; an independent monitor pops and
// compares whenever the DUT raises dice_valid or pulses timeout_err, and also
// checks the per-cycle status outputs against the model.
// -----------------------------------------------------------------------------
module tb_dice_roll_qualifier;

  localparam int SC = 4;
  localparam int RF = 8;
  localparam int TO = 60;

  localparam int P_IDLE   = 0;
  localparam int P_REARM  = 1;
  localparam int P_ARMED  = 2;
  localparam int P_SETTLE = 3;
  localparam int P_REPORT = 4;
  localparam int EV_TIMEOUT = 4;   // results are 0..3, timeout is event 4

  logic clk = 1'b0;
  logic reset;

  dice_roll_qualifier_if bus ();

  dice_roll_qualifier #(
    .SETTLE_COUNT  (SC),
    .REARM_FRAMES  (RF),
    .TIMEOUT_FRAMES(TO),
    .CNT_W         (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- counters and scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_phase = P_IDLE;
  int m_white_run, m_agree, m_ticks, m_cand, m_value;
  bit m_valid, m_timeout, m_after_reset;

  task automatic model_step(input bit rst, en, tick, cv, input int code, input bit white, ack);
    bit left;
    m_timeout     = 1'b0;
    m_after_reset = 1'b0;
    if (rst) begin
      m_phase = P_IDLE; m_white_run = 0; m_agree = 0; m_ticks = 0; m_cand = 0;
      m_valid = 1'b0; m_value = 0; m_after_reset = 1'b1;
    end else if (!en) begin
      m_phase = P_IDLE; m_white_run = 0; m_agree = 0; m_ticks = 0;
      m_valid = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          m_phase = P_REARM; m_white_run = 0;
        end
        P_REARM: if (tick) begin
          if (white) begin
            m_white_run++;
            if (m_white_run == RF) m_phase = P_ARMED;
          end else m_white_run = 0;
        end
        P_ARMED: if (cv && !white) begin
          m_cand = code; m_agree = 1; m_ticks = 0;
          if (m_agree == SC) begin
            m_phase = P_REPORT; m_valid = 1'b1; m_value = m_cand; exp_q.push_back(m_cand);
          end else m_phase = P_SETTLE;
        end
        P_SETTLE: begin
          left = 1'b0;
          if (cv) begin
            if (white) begin
              m_phase = P_ARMED; m_agree = 0; left = 1'b1;
            end else if (code == m_cand) begin
              m_agree++;
              if (m_agree == SC) begin
                m_phase = P_REPORT; m_valid = 1'b1; m_value = m_cand;
                exp_q.push_back(m_cand); left = 1'b1;
              end
            end else begin
              m_cand = code; m_agree = 1;
            end
          end
          if (tick && !left) begin
            m_ticks++;
            if (m_ticks == TO) begin
              m_timeout = 1'b1; m_phase = P_REARM; m_white_run = 0;
              exp_q.push_back(EV_TIMEOUT);
            end
          end
        end
        P_REPORT: if (ack && m_valid) begin
          m_valid = 1'b0; m_phase = P_REARM; m_white_run = 0;
        end
        default: m_phase = P_IDLE;
      endcase
    end
  endtask

  // ---------------- stimulus helpers ----------------
  bit mon_en = 1'b0;

  task automatic cyc(input bit rst, en, tick, cv, input int code, input bit white, ack);
    @(negedge clk);
    reset             = rst;
    bus.enable        = en;
    bus.frame_tick    = tick;
    bus.color_valid   = cv;
    bus.color_code    = 2'(code);
    bus.white_present = white;
    bus.dice_ack      = ack;
    model_step(rst, en, tick, cv, code, white, ack);
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0, 0);
  endtask

  // RF white frame ticks, with a quiet cycle between ticks.
  task automatic rearm();
    for (int i = 0; i < RF; i++) begin
      cyc(0, 1, 1, 0, 0, 1, 0);
      idle(1);
    end
  endtask

  task automatic sample(input int code);
    cyc(0, 1, 0, 1, code, 0, 0);
    idle(1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  bit prev_valid = 1'b0;

  always @(posedge clk) begin
    int act;
    #1;
    if (mon_en) begin
      check("state_dbg",   32'(bus.state_dbg),   32'(m_phase));
      check("busy",        32'(bus.busy),        32'(m_phase == P_SETTLE || m_phase == P_REPORT));
      check("dice_valid",  32'(bus.dice_valid),  32'(m_valid));
      check("timeout_err", 32'(bus.timeout_err), 32'(m_timeout));
      if (m_valid || m_after_reset) begin
        check("dice_value", 32'(bus.dice_value), 32'(m_value));
        check("dice_steps", 32'(bus.dice_steps), 32'(m_value + 1));
      end
      if ((bus.dice_valid && !prev_valid) || bus.timeout_err) begin
        act = bus.timeout_err ? EV_TIMEOUT : int'(bus.dice_value);
        if (exp_q.size() == 0) check("event_expected", 32'(exp_q.size()), 32'd1);
        else check("event", 32'(act), 32'(exp_q.pop_front()));
      end
      prev_valid = bus.dice_valid;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit tray_white;
    int die;
    reset = 1'b1;
    bus.enable = 1'b0; bus.frame_tick = 1'b0; bus.color_valid = 1'b0;
    bus.color_code = 2'd0; bus.white_present = 1'b0; bus.dice_ack = 1'b0;

    // Reset, then a stray ack while IDLE.
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Normal roll, with a stray ack in ARMED first.
    cyc(0, 1, 0, 0, 0, 0, 0);
    rearm();
    cyc(0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) sample(2);
    idle(3);
    cyc(0, 1, 0, 0, 0, 0, 1);

    // Lockout: the same dice keeps being seen, no white frames.
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 1, 2, 0, 0);

    // Flicker 1,1,3,3,3,3 settles to 3.
    rearm();
    sample(1); sample(1);
    for (int i = 0; i < 4; i++) sample(3);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0, 1);

    // 1,1 then white: back to ARMED.
    rearm();
    sample(1); sample(1);
    cyc(0, 1, 0, 1, 1, 1, 0);
    idle(2);

    // Timeout after 60 ticks without agreement.
    sample(0);
    ticks(TO);
    idle(2);

    // Settle completes on the same cycle as the 60th tick: no timeout.
    rearm();
    sample(0); sample(0); sample(0);
    ticks(TO - 1);
    cyc(0, 1, 1, 1, 0, 0, 0);
    idle(2);

    // Enable drop while reporting.
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Reset in the middle of a settle.
    rearm();
    sample(1); sample(2);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    // Randomized traffic: a tray that alternates between empty and holding a
    // dice, noisy colour samples, random acks, rare enable drops and resets.
    tray_white = 1'b1;
    die = 0;
    for (int i = 0; i < 6000; i++) begin
      bit r, e, t, v, a;
      int c;
      if ($urandom_range(0, 79) == 0) tray_white = !tray_white;
      if ($urandom_range(0, 29) == 0) die = int'($urandom_range(0, 3));
      r = ($urandom_range(0, 999) == 0);
      e = ($urandom_range(0, 299) != 0);
      t = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : die;
      a = ($urandom_range(0, 7) == 0);
      cyc(r, e, t, v, c, tray_white, a);
    end
    idle(3);

    @(posedge clk);
    #2;
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
